// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencing controller.
// The load-use comparator and the top-level controller both import this package.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } pipe_state_t;

  localparam int REG_W  = 4;
  localparam int WAIT_W = 8;

  function automatic logic reg_match(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] dest,
    input logic             src_used
  );
    return src_used && (src == dest);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use hazard comparator: a load in EX whose destination feeds a source
// operand of the instruction in ID. Register r0 is compared like any other.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_r2,
  input  logic [REG_W-1:0] id_r3,
  input  logic             id_use_r2,
  input  logic             id_use_r3,
  input  logic             ex_rmem,
  input  logic [REG_W-1:0] ex_dest,
  output logic             hazard
);

  assign hazard = ex_rmem && (reg_match(id_r2, ex_dest, id_use_r2) ||
                              reg_match(id_r3, ex_dest, id_use_r3));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: memory-wait freeze with timeout, MEM-stage
// redirect flushes, load-use bubbles, and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_r2,
  input  logic [REG_W-1:0] id_r3,
  input  logic             id_use_r2,
  input  logic             id_use_r3,
  input  logic             ex_rmem,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_wmem,
  input  logic             mem_rmem,
  input  logic             mem_wpc,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mem_req,
  output logic             mem_err,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  pipe_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_acc;
  logic hazard;
  logic freeze;
  logic stall_inc;
  logic flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  load_use_detect u_load_use (
    .id_r2     (id_r2),
    .id_r3     (id_r3),
    .id_use_r2 (id_use_r2),
    .id_use_r3 (id_use_r3),
    .ex_rmem   (ex_rmem),
    .ex_dest   (ex_dest),
    .hazard    (hazard)
  );

  assign mem_acc = mem_wmem | mem_rmem;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mem_req     = 1'b0;
    busy        = 1'b0;
    freeze      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;

    if (state_q == RUN) begin
      mem_req = mem_acc;
      freeze  = mem_acc && !mem_ack;
    end else begin
      mem_req = 1'b1;
      busy    = 1'b1;
      freeze  = !(mem_ack || (wait_cnt_q == WAIT_LAST));
    end

    if (freeze) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      stall_inc = 1'b1;
      if (state_q == RUN) begin
        state_d    = MEMWAIT;
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      if (state_q == MEMWAIT) begin
        state_d    = RUN;
        wait_cnt_d = '0;
        // Releasing without an ack means the wait budget ran out.
        if (!mem_ack) err_d = 1'b1;
      end
      if (mem_wpc) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (hazard) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end

    stall_cnt_d = stall_inc ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush_inc ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: combinational vector table, directed hazard
// sequences and randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_r2, id_r3, ex_dest;
  logic       id_use_r2, id_use_r3, ex_rmem;
  logic       mem_wmem, mem_rmem, mem_wpc, mem_ack;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic       mem_req, mem_err, busy;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [9:0] dut_ctl;

  int checks   = 0;
  int failures = 0;

  bit m_wait;
  int m_waited;
  bit m_err;
  int m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_r2(id_r2), .id_r3(id_r3), .id_use_r2(id_use_r2), .id_use_r3(id_use_r3),
    .ex_rmem(ex_rmem), .ex_dest(ex_dest),
    .mem_wmem(mem_wmem), .mem_rmem(mem_rmem), .mem_wpc(mem_wpc), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .mem_req(mem_req), .mem_err(mem_err), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign dut_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, mem_req, busy};

  typedef struct packed {
    logic [3:0] r2;
    logic [3:0] r3;
    logic       u2;
    logic       u3;
    logic       exr;
    logic [3:0] dest;
    logic       wm;
    logic       rm;
    logic       wpc;
    logic       ack;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_r2 = 4'd0; id_r3 = 4'd0; id_use_r2 = 1'b0; id_use_r3 = 1'b0;
    ex_rmem = 1'b0; ex_dest = 4'd0;
    mem_wmem = 1'b0; mem_rmem = 1'b0; mem_wpc = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic load_use_on(input logic [3:0] r);
    ex_rmem = 1'b1; ex_dest = r; id_r3 = r; id_use_r3 = 1'b1;
  endtask

  // Expected {enables, flushes, mem_req, busy} from the hazard rules.
  function automatic logic [9:0] model_ctl();
    bit acc   = mem_wmem || mem_rmem;
    bit hz    = ex_rmem && ((id_use_r2 && id_r2 == ex_dest) || (id_use_r3 && id_r3 == ex_dest));
    bit stuck = m_wait ? !(mem_ack || m_waited == TO - 1) : (acc && !mem_ack);
    bit req   = m_wait ? 1'b1 : acc;
    if (stuck)   return {5'b00000, 3'b000, req, m_wait};
    if (mem_wpc) return {5'b11111, 3'b111, req, m_wait};
    if (hz)      return {5'b00111, 3'b010, req, m_wait};
    return {5'b11111, 3'b000, req, m_wait};
  endfunction

  task automatic cyc(input string tag);
    logic [9:0] e;
    bit frz, redir, lu;
    @(negedge clk);
    e = model_ctl();
    chk({tag, " ctl"}, 32'(dut_ctl), 32'(e));
    chk({tag, " cnt"}, 32'({stall_cnt, flush_cnt, mem_err}),
        32'({m_stall[3:0], m_flush[3:0], m_err}));
    frz   = (e[9:5] == 5'b00000);
    redir = e[2];
    lu    = e[3] && !e[2];
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else if (frz) begin
      m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (m_wait) m_waited++;
      else begin m_wait = 1; m_waited = 0; end
    end else begin
      if (m_wait && !mem_ack) m_err = 1;
      m_wait = 0; m_waited = 0;
      if (redir)   m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      else if (lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc("reset");
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b11111_000_00};
    vecs[1]  = '{4'd1, 4'd5, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 10'b00111_010_00};
    vecs[2]  = '{4'd7, 4'd2, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 10'b11111_000_00};
    vecs[3]  = '{4'd7, 4'd2, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 10'b00111_010_00};
    vecs[4]  = '{4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b00111_010_00};
    vecs[5]  = '{4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 10'b11111_000_00};
    vecs[6]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'b00000_000_10};
    vecs[7]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'b11111_000_10};
    vecs[8]  = '{4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 10'b11111_111_00};
    vecs[9]  = '{4'd4, 4'd0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 10'b00000_000_10};
    vecs[10] = '{4'd0, 4'd6, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 10'b00111_010_10};
    vecs[11] = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'b11111_111_00};

    // Held in reset the controller stays in RUN, so each vector is a pure
    // combinational lookup from the RUN state.
    rst = 1'b1;
    idle();
    m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      id_r2 = vecs[i].r2; id_r3 = vecs[i].r3; id_use_r2 = vecs[i].u2; id_use_r3 = vecs[i].u3;
      ex_rmem = vecs[i].exr; ex_dest = vecs[i].dest;
      mem_wmem = vecs[i].wm; mem_rmem = vecs[i].rm; mem_wpc = vecs[i].wpc; mem_ack = vecs[i].ack;
      #2;
      chk($sformatf("vec%0d", i), 32'(dut_ctl), 32'(vecs[i].exp));
    end
    do_reset();
    chk("reset counters", 32'({stall_cnt, flush_cnt, mem_err, busy}), 32'(0));

    // Load-use: one bubble, then the pipeline flows again.
    do_reset();
    load_use_on(4'd5);
    #1 chk("lu bubble", 32'(dut_ctl), 32'(10'b00111_010_00));
    cyc("lu");
    chk("lu stall_cnt", 32'(stall_cnt), 32'(1));
    idle(); mem_rmem = 1'b1; mem_ack = 1'b1;
    #1 chk("lu after", 32'(dut_ctl), 32'(10'b11111_000_10));
    cyc("lu2");

    // Memory wait: ack three cycles after the access appears.
    do_reset();
    mem_rmem = 1'b1;
    cyc("mw0");
    chk("mw busy", 32'(busy), 32'(1));
    cyc("mw1");
    cyc("mw2");
    mem_ack = 1'b1;
    #1 chk("mw release", 32'(dut_ctl), 32'(10'b11111_000_11));
    cyc("mw3");
    chk("mw stall_cnt", 32'(stall_cnt), 32'(3));
    chk("mw busy end", 32'(busy), 32'(0));

    // Timeout: store never acked; error sticks until reset.
    do_reset();
    mem_wmem = 1'b1;
    repeat (4) cyc("to");
    #1 chk("to release", 32'(dut_ctl), 32'(10'b11111_000_11));
    cyc("to rel");
    chk("to mem_err", 32'(mem_err), 32'(1));
    chk("to stall_cnt", 32'(stall_cnt), 32'(4));
    idle(); mem_rmem = 1'b1; mem_ack = 1'b1;
    repeat (3) cyc("to traffic");
    chk("to err sticky", 32'(mem_err), 32'(1));
    do_reset();
    chk("to err cleared", 32'(mem_err), 32'(0));

    // Redirect wins over a simultaneous load-use.
    do_reset();
    mem_wpc = 1'b1;
    load_use_on(4'd9);
    #1 chk("redir ctl", 32'(dut_ctl), 32'(10'b11111_111_00));
    cyc("redir");
    chk("redir flush_cnt", 32'(flush_cnt), 32'(1));
    chk("redir stall_cnt", 32'(stall_cnt), 32'(0));

    // Reset during the second wait cycle abandons the access.
    do_reset();
    mem_rmem = 1'b1;
    cyc("rmw entry");
    cyc("rmw wait1");
    rst = 1'b1;
    cyc("rmw wait2");
    rst = 1'b0;
    mem_rmem = 1'b0;
    #1;
    chk("rmw busy", 32'(busy), 32'(0));
    chk("rmw counters", 32'({stall_cnt, flush_cnt}), 32'(0));
    chk("rmw enables", 32'(dut_ctl), 32'(10'b11111_000_00));

    // Stall counter saturation at all-ones.
    do_reset();
    load_use_on(4'd2);
    repeat (20) cyc("sat");
    chk("sat stall_cnt", 32'(stall_cnt), 32'(15));

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      id_r2     = 4'($urandom_range(0, 3));
      id_r3     = 4'($urandom_range(0, 3));
      ex_dest   = 4'($urandom_range(0, 3));
      id_use_r2 = 1'($urandom_range(0, 1));
      id_use_r3 = 1'($urandom_range(0, 1));
      ex_rmem   = 1'($urandom_range(0, 1));
      mem_wmem  = ($urandom_range(0, 4) == 0);
      mem_rmem  = ($urandom_range(0, 4) == 0);
      mem_wpc   = ($urandom_range(0, 5) == 0);
      mem_ack   = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 39) == 0);
      cyc("rnd");
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
